filter_out_sink: RTL and testbench

FILTER_OUT_SINK -- requirements
Module: filter_out_sink

---
 rtl/filter_out_sink.sv | 133 +++++++++++++
 tb/tb_filter_out_sink.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/filter_out_sink.sv
// filter_out_sink: capture stage for the filter unit's output stream.
// Each accepted capture writes one sample into a first-word-fall-through FIFO
// that a downstream consumer drains with a valid/ready handshake.
// Captures that arrive while the FIFO is full and nothing is being popped are
// dropped. A drop sets a sticky overflow flag and bumps a saturating counter.
//
// Parameters:
//   DATABITS  - sample width (matches the filter output width)
//   DEPTH     - FIFO depth in words, power of two, >= 2
//   EDGE_MODE - 1: capture on each 0->1 edge of data_valid_in
//               0: capture on every cycle data_valid_in is high
// Ports:
//   clk           - clock, rising edge
//   rst           - synchronous active-high reset, highest priority
//   clr_in        - synchronous flush of FIFO, flags and counters
//   data_in       - filtered sample
//   data_valid_in - sample qualifier from the filter
//   ready_in      - downstream consumer ready
//   data_out      - FIFO head word (don't-care while valid_out is low)
//   valid_out     - FIFO not empty
//   count_out     - FIFO occupancy, 0..DEPTH
//   overflow_out  - sticky: at least one capture was dropped
//   drop_cnt_out  - number of dropped captures, saturates at 255
module filter_out_sink #(
  parameter int unsigned DATABITS  = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned EDGE_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_in,
  input  logic [DATABITS-1:0]        data_in,
  input  logic                       data_valid_in,
  input  logic                       ready_in,
  output logic [DATABITS-1:0]        data_out,
  output logic                       valid_out,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       overflow_out,
  output logic [7:0]                 drop_cnt_out
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATABITS-1:0] mem [DEPTH];
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic                vin_q;

  logic capture, pop, push, full, drop;

  // Capture rule.
  if (EDGE_MODE != 0) begin : g_edge
    assign capture = data_valid_in & ~vin_q;
  end else begin : g_level
    assign capture = data_valid_in;
  end

  assign full = (count_q == CntW'(DEPTH));
  assign pop  = valid_out & ready_in;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = capture & (~full | pop);
  assign drop = capture & full & ~pop;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      vin_q      <= 1'b0;
    end else if (clr_in) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      // Track the live input so a level held across the flush is not a new edge.
      vin_q      <= data_valid_in;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      vin_q      <= data_valid_in;
    end
  end

  // Storage has no reset; occupancy alone says which words are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && !clr_in && push) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  // Head is read from storage only, never bypassed from data_in.
  assign data_out     = mem[rd_ptr_q];
  assign valid_out    = (count_q != '0);
  assign count_out    = count_q;
  assign overflow_out = overflow_q;
  assign drop_cnt_out = drop_cnt_q;

endmodule

// File: tb/tb_filter_out_sink.sv
// Directed bench for filter_out_sink. Two instances share all inputs: one in
// edge-capture mode, one in level-capture mode; each test checks the instance
// whose capture rule it targets. Inputs change 1 time unit after the rising
// edge and outputs are sampled at the same point.
module tb_filter_out_sink;

  logic        clk = 1'b0;
  logic        rst, clr_in, data_valid_in, ready_in;
  logic [15:0] data_in;

  logic [15:0] data_e, data_z;
  logic        valid_e, valid_z, ovf_e, ovf_z;
  logic [3:0]  count_e, count_z;
  logic [7:0]  drop_e, drop_z;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  filter_out_sink #(.DATABITS(16), .DEPTH(8), .EDGE_MODE(1)) u_edge (
    .clk           (clk),
    .rst           (rst),
    .clr_in        (clr_in),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .ready_in      (ready_in),
    .data_out      (data_e),
    .valid_out     (valid_e),
    .count_out     (count_e),
    .overflow_out  (ovf_e),
    .drop_cnt_out  (drop_e)
  );

  filter_out_sink #(.DATABITS(16), .DEPTH(8), .EDGE_MODE(0)) u_level (
    .clk           (clk),
    .rst           (rst),
    .clr_in        (clr_in),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .ready_in      (ready_in),
    .data_out      (data_z),
    .valid_out     (valid_z),
    .count_out     (count_z),
    .overflow_out  (ovf_z),
    .drop_cnt_out  (drop_z)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One-cycle valid pulse followed by one idle cycle: one capture in both modes.
  task automatic pulse(input logic [15:0] v);
    data_in       = v;
    data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    tick();
  endtask

  initial begin
    int idx;
    rst = 1'b0; clr_in = 1'b0; data_valid_in = 1'b0; ready_in = 1'b0; data_in = '0;
    tick();
    do_reset();

    // Reset state
    check("rst_count", 32'(count_e), 32'd0);
    check("rst_valid", 32'(valid_e), 32'd0);
    check("rst_ovf",   32'(ovf_e),   32'd0);
    check("rst_drop",  32'(drop_e),  32'd0);

    // Three pulses, then drain in order; empty FIFO must not bypass data_in
    data_in = 16'h0010; data_valid_in = 1'b1;
    check("no_bypass", 32'(valid_e), 32'd0);
    tick();
    data_valid_in = 1'b0;
    tick();
    pulse(16'h0020);
    pulse(16'h0030);
    check("three_count", 32'(count_e), 32'd3);
    check("three_head",  32'(data_e),  32'h0010);
    ready_in = 1'b1;
    check("pop0", 32'(data_e), 32'h0010);
    tick();
    check("pop1", 32'(data_e), 32'h0020);
    tick();
    check("pop2", 32'(data_e), 32'h0030);
    check("pop2_valid", 32'(valid_e), 32'd1);
    tick();
    check("pop_empty", 32'(valid_e), 32'd0);
    ready_in = 1'b0;

    // Ten captures into depth 8: two drops, drain yields 1..8
    do_reset();
    for (int i = 1; i <= 10; i++) pulse(16'(i));
    check("ovf_count", 32'(count_e), 32'd8);
    check("ovf_flag",  32'(ovf_e),   32'd1);
    check("ovf_drop",  32'(drop_e),  32'd2);
    ready_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain%0d", i), 32'(data_e), 32'(i));
      tick();
    end
    check("drain_empty", 32'(valid_e), 32'd0);
    ready_in = 1'b0;

    // Full FIFO, capture and pop together: no drop, new word last out
    do_reset();
    for (int i = 1; i <= 8; i++) pulse(16'(i));
    data_in = 16'h00AA; data_valid_in = 1'b1; ready_in = 1'b1;
    tick();
    data_valid_in = 1'b0; ready_in = 1'b0;
    check("full_pp_count", 32'(count_e), 32'd8);
    check("full_pp_drop",  32'(drop_e),  32'd0);
    check("full_pp_ovf",   32'(ovf_e),   32'd0);
    ready_in = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      check($sformatf("full_pp_out%0d", i), 32'(data_e), 32'(i));
      tick();
    end
    check("full_pp_last", 32'(data_e), 32'h00AA);
    tick();
    check("full_pp_empty", 32'(valid_e), 32'd0);
    ready_in = 1'b0;

    // Held valid: one entry in edge mode, one per cycle in level mode
    do_reset();
    data_in = 16'h7FFF; data_valid_in = 1'b1;
    repeat (5) tick();
    data_valid_in = 1'b0;
    tick();
    check("hold_count_edge",  32'(count_e), 32'd1);
    check("hold_head_edge",   32'(data_e),  32'h7FFF);
    check("hold_count_level", 32'(count_z), 32'd5);

    // Drop counter saturates at 255
    do_reset();
    for (int i = 0; i < 8 + 260; i++) pulse(16'(i));
    check("drop_sat", 32'(drop_e), 32'd255);

    // Level mode, 20 back-to-back captures with ready high: pointers wrap twice
    do_reset();
    ready_in = 1'b1;
    idx = 0;
    for (int i = 0; i < 20; i++) begin
      data_in = 16'h0100 + 16'(i); data_valid_in = 1'b1;
      if (valid_z) begin
        check($sformatf("stream%0d", idx), 32'(data_z), 32'h100 + 32'(idx));
        idx++;
      end
      tick();
    end
    data_valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (valid_z) begin
        check($sformatf("stream%0d", idx), 32'(data_z), 32'h100 + 32'(idx));
        idx++;
      end
      tick();
    end
    check("stream_total", 32'(idx),    32'd20);
    check("stream_drop",  32'(drop_z), 32'd0);
    check("stream_ovf",   32'(ovf_z),  32'd0);
    ready_in = 1'b0;

    // clr_in with count 5, overflow set, and a capture pending
    do_reset();
    for (int i = 1; i <= 9; i++) pulse(16'(i));
    ready_in = 1'b1;
    repeat (3) tick();
    ready_in = 1'b0;
    check("pre_clr_count", 32'(count_e), 32'd5);
    check("pre_clr_ovf",   32'(ovf_e),   32'd1);
    data_in = 16'h0099; data_valid_in = 1'b1; ready_in = 1'b1; clr_in = 1'b1;
    tick();
    clr_in = 1'b0; ready_in = 1'b0;
    check("clr_count", 32'(count_e), 32'd0);
    check("clr_valid", 32'(valid_e), 32'd0);
    check("clr_ovf",   32'(ovf_e),   32'd0);
    check("clr_drop",  32'(drop_e),  32'd0);
    // Valid still high after the flush is not a fresh edge
    tick();
    check("clr_no_edge", 32'(count_e), 32'd0);
    data_valid_in = 1'b0;
    tick();

    // rst with count 5, overflow set, and a capture pending
    for (int i = 1; i <= 9; i++) pulse(16'(i));
    ready_in = 1'b1;
    repeat (3) tick();
    ready_in = 1'b0;
    check("pre_rst_count", 32'(count_e), 32'd5);
    data_in = 16'h0099; data_valid_in = 1'b1; ready_in = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; data_valid_in = 1'b0; ready_in = 1'b0;
    check("rst2_count", 32'(count_e), 32'd0);
    check("rst2_valid", 32'(valid_e), 32'd0);
    check("rst2_ovf",   32'(ovf_e),   32'd0);
    check("rst2_drop",  32'(drop_e),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
